// File: rtl/lstm_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | lstm_sched_pkg                                                             |
// | Shared types and helpers for the LSTM forward-pass sequencer.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package lstm_sched_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_XPH   = 3'd1,
      ST_HPH   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } sched_state_t;

   // True when a*b is addressable with w bits.
   function automatic bit addr_fits(input int unsigned a, input int unsigned b,
                                    input int unsigned w);
      return (64'(a) * 64'(b)) < (64'd1 << w);
   endfunction

   function automatic int cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sched_base_cnt.sv
// +----------------------------------------------------------------------------+
// | sched_base_cnt                                                             |
// | Base+offset address counter: rewind to base, step base by STRIDE, or +1.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sched_base_cnt #(
   parameter int ADDR_WIDTH = 12,
   parameter int STRIDE     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_hold,
   input  logic                  i_clr,
   input  logic                  i_load_base,
   input  logic                  i_add_stride,
   input  logic                  i_inc,
   output logic [ADDR_WIDTH-1:0] o_addr
);

   localparam logic [ADDR_WIDTH-1:0] c_STRIDE = ADDR_WIDTH'(STRIDE);
   localparam logic [ADDR_WIDTH-1:0] c_ONE    = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_base <= '0;
         r_addr <= '0;
      end else if (!i_hold) begin
         if (i_clr) begin
            r_base <= '0;
            r_addr <= '0;
         end else if (i_add_stride) begin
            r_base <= r_base + c_STRIDE;
            r_addr <= r_base + c_STRIDE;
         end else if (i_load_base) begin
            r_addr <= r_base;
         end else if (i_inc) begin
            r_addr <= r_addr + c_ONE;
         end
      end
   end

   assign o_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/lstm_fwd_sched.sv
// +----------------------------------------------------------------------------+
// | lstm_fwd_sched                                                             |
// | Forward-pass sequencer for one LSTM layer (x*W, h*U, drain, writeback).    |
// | Option: LSTM_FWD_SKIP_H0_EN skips the h*U phase at t=0.                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module lstm_fwd_sched
   import lstm_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int TIMESTEP   = 7,
   parameter int NUM_INPUT  = 53,
   parameter int NUM_CELL   = 53,
   parameter int DELAY      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stall,
   output logic                  busy,
   output logic                  done,
   output logic                  acc_x,
   output logic                  acc_h,
   output logic                  rst_acc,
   output logic                  wr_act,
   output logic                  wr_c,
   output logic                  wr_h,
   output logic [ADDR_WIDTH-1:0] addr_x,
   output logic [ADDR_WIDTH-1:0] addr_w,
   output logic [ADDR_WIDTH-1:0] addr_u,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [ADDR_WIDTH-1:0] rd_addr_h,
   output logic [ADDR_WIDTH-1:0] wr_addr_hc,
   output logic [2:0]            timestep
);

   localparam int c_I_W = cnt_w(NUM_INPUT);
   localparam int c_J_W = cnt_w(NUM_CELL);
   localparam int c_D_W = cnt_w(DELAY);

   localparam logic [c_I_W-1:0] c_I_LAST = c_I_W'(NUM_INPUT - 1);
   localparam logic [c_J_W-1:0] c_J_LAST = c_J_W'(NUM_CELL - 1);
   localparam logic [c_D_W-1:0] c_D_LAST = c_D_W'(DELAY - 1);
   localparam logic [2:0]       c_T_LAST = 3'(TIMESTEP - 1);
   localparam logic [c_I_W-1:0] c_I_ONE  = c_I_W'(1);
   localparam logic [c_J_W-1:0] c_J_ONE  = c_J_W'(1);
   localparam logic [c_D_W-1:0] c_D_ONE  = c_D_W'(1);

   if (!addr_fits(TIMESTEP, NUM_INPUT, ADDR_WIDTH) ||
       !addr_fits(NUM_CELL, NUM_CELL, ADDR_WIDTH) || TIMESTEP > 8) begin : g_width_err
      $error("lstm_fwd_sched: ADDR_WIDTH or timestep width too small for configuration");
   end

   sched_state_t     r_state;
   sched_state_t     w_state_nxt;
   logic [c_I_W-1:0] r_i;
   logic [c_J_W-1:0] r_j;
   logic [c_J_W-1:0] r_cell;
   logic [c_D_W-1:0] r_drain;
   logic [2:0]       r_t;

   logic w_freeze, w_start, w_write, w_t0, w_skip_h;
   logic w_i_last, w_j_last, w_d_last, w_cell_last, w_t_last;
   logic w_x_step, w_h_step;

   // Stall is ignored in IDLE so a start is never lost.
   assign w_freeze    = stall && (r_state != ST_IDLE);
   assign w_start     = (r_state == ST_IDLE) && start;
   assign w_write     = (r_state == ST_WRITE);
   assign w_t0        = (r_t == 3'd0);
   assign w_i_last    = (r_i == c_I_LAST);
   assign w_j_last    = (r_j == c_J_LAST);
   assign w_d_last    = (r_drain == c_D_LAST);
   assign w_cell_last = (r_cell == c_J_LAST);
   assign w_t_last    = (r_t == c_T_LAST);
   assign w_x_step    = (r_state == ST_XPH) && !w_i_last;
   assign w_h_step    = (r_state == ST_HPH) && !w_j_last;

`ifdef LSTM_FWD_SKIP_H0_EN
   assign w_skip_h = w_t0;
`else
   assign w_skip_h = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      acc_x       = 1'b0;
      acc_h       = 1'b0;
      rst_acc     = 1'b0;
      wr_act      = 1'b0;
      unique case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_XPH;
         ST_XPH: begin
            busy  = 1'b1;
            acc_x = !stall;
            if (!stall && w_i_last) w_state_nxt = w_skip_h ? ST_DRAIN : ST_HPH;
         end
         ST_HPH: begin
            busy  = 1'b1;
            acc_h = !stall && !w_t0;
            if (!stall && w_j_last) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (!stall && w_d_last) w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            busy    = 1'b1;
            rst_acc = !stall;
            wr_act  = !stall;
            if (!stall) w_state_nxt = (w_cell_last && w_t_last) ? ST_DONE : ST_XPH;
         end
         ST_DONE: begin
            done = !stall;
            if (!stall) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign wr_c = wr_act;
   assign wr_h = wr_act;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_t     <= '0;
         r_cell  <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_drain <= '0;
      end else if (!w_freeze) begin
         case (r_state)
            ST_IDLE: if (start) begin
               r_t     <= '0;
               r_cell  <= '0;
               r_i     <= '0;
               r_j     <= '0;
               r_drain <= '0;
            end
            ST_XPH: begin
               if (w_i_last) begin
                  r_i     <= '0;
                  r_j     <= '0;
                  r_drain <= '0;
               end else begin
                  r_i <= r_i + c_I_ONE;
               end
            end
            ST_HPH:   r_j     <= w_j_last ? '0 : r_j + c_J_ONE;
            ST_DRAIN: r_drain <= w_d_last ? '0 : r_drain + c_D_ONE;
            ST_WRITE: begin
               if (w_cell_last) begin
                  r_cell <= '0;
                  r_t    <= w_t_last ? 3'd0 : r_t + 3'd1;
               end else begin
                  r_cell <= r_cell + c_J_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // x rewinds to t*NUM_INPUT per cell; h stays at base 0 until t advances past 1.
   sched_base_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .STRIDE(NUM_INPUT)) u_cnt_x (
      .clk(clk), .rst(rst), .i_hold(w_freeze), .i_clr(w_start),
      .i_load_base(w_write && !w_cell_last), .i_add_stride(w_write && w_cell_last),
      .i_inc(w_x_step), .o_addr(addr_x));

   sched_base_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .STRIDE(NUM_INPUT)) u_cnt_w (
      .clk(clk), .rst(rst), .i_hold(w_freeze), .i_clr(w_start || (w_write && w_cell_last)),
      .i_load_base(1'b0), .i_add_stride(w_write && !w_cell_last),
      .i_inc(w_x_step), .o_addr(addr_w));

   sched_base_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .STRIDE(NUM_CELL)) u_cnt_u (
      .clk(clk), .rst(rst), .i_hold(w_freeze), .i_clr(w_start || (w_write && w_cell_last)),
      .i_load_base(1'b0), .i_add_stride(w_write && !w_cell_last),
      .i_inc(w_h_step), .o_addr(addr_u));

   sched_base_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .STRIDE(NUM_CELL)) u_cnt_h (
      .clk(clk), .rst(rst), .i_hold(w_freeze), .i_clr(w_start),
      .i_load_base(w_write && (!w_cell_last || w_t0)),
      .i_add_stride(w_write && w_cell_last && !w_t0),
      .i_inc(w_h_step && !w_t0), .o_addr(rd_addr_h));

   // t*NUM_CELL+cell is contiguous across cells and timesteps.
   sched_base_cnt #(.ADDR_WIDTH(ADDR_WIDTH), .STRIDE(1)) u_cnt_wr (
      .clk(clk), .rst(rst), .i_hold(w_freeze), .i_clr(w_start),
      .i_load_base(1'b0), .i_add_stride(1'b0),
      .i_inc(w_write), .o_addr(wr_addr_hc));

   assign addr_b   = ADDR_WIDTH'(r_cell);
   assign timestep = r_t;

endmodule

`default_nettype wire

// File: tb/tb_lstm_fwd_sched.sv
// +----------------------------------------------------------------------------+
// | tb_lstm_fwd_sched                                                          |
// | Directed bench for lstm_fwd_sched in a small configuration.                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lstm_fwd_sched;

   localparam int AW = 12;
   localparam int TS = 2;
   localparam int NI = 3;
   localparam int NC = 2;
   localparam int DL = 1;
`ifdef LSTM_FWD_SKIP_H0_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   localparam int CELL_T0 = SKIP ? 5 : 7;
   localparam int TOTAL   = SKIP ? 24 : 28;
   localparam int CAP_N   = 128;

   logic          clk = 1'b0;
   logic          rst, start, stall;
   logic          busy, done, acc_x, acc_h, rst_acc, wr_act, wr_c, wr_h;
   logic [AW-1:0] addr_x, addr_w, addr_u, addr_b, rd_addr_h, wr_addr_hc;
   logic [2:0]    timestep;

   always #5 clk = ~clk;

   lstm_fwd_sched #(
      .ADDR_WIDTH(AW), .TIMESTEP(TS), .NUM_INPUT(NI), .NUM_CELL(NC), .DELAY(DL)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .busy(busy), .done(done), .acc_x(acc_x), .acc_h(acc_h), .rst_acc(rst_acc),
      .wr_act(wr_act), .wr_c(wr_c), .wr_h(wr_h),
      .addr_x(addr_x), .addr_w(addr_w), .addr_u(addr_u), .addr_b(addr_b),
      .rd_addr_h(rd_addr_h), .wr_addr_hc(wr_addr_hc), .timestep(timestep)
   );

   typedef struct packed {
      logic          busy, done, acc_x, acc_h, rst_acc, wr_act, wr_c, wr_h;
      logic [AW-1:0] addr_x, addr_w, addr_u, addr_b, rd_addr_h, wr_addr_hc;
      logic [2:0]    timestep;
   } snap_t;

   snap_t cap   [CAP_N];
   snap_t exp_a [CAP_N];
   snap_t msk_a [CAP_N];
   int    model_len;
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic snap_t take_snap();
      return {busy, done, acc_x, acc_h, rst_acc, wr_act, wr_c, wr_h,
              addr_x, addr_w, addr_u, addr_b, rd_addr_h, wr_addr_hc, timestep};
   endfunction

   function automatic snap_t strobe_mask();
      snap_t m = '0;
      {m.busy, m.done, m.acc_x, m.acc_h, m.rst_acc, m.wr_act, m.wr_c, m.wr_h} = 8'hFF;
      return m;
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse_start(input logic with_stall);
      @(posedge clk);
      #1 start = 1'b1; stall = with_stall;
   endtask

   // Cycle 0 of the capture is the cycle after the start-pulse cycle.
   task automatic capture(input int n, input int a_from, input int a_len,
                          input int b_from, input int b_len, input int rst_at,
                          input logic hold_start);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         start = hold_start;
         stall = (k >= a_from && k < a_from + a_len) || (k >= b_from && k < b_from + b_len);
         rst   = (k == rst_at);
         @(negedge clk);
         cap[k] = take_snap();
      end
      @(posedge clk);
      #1 start = 1'b0; stall = 1'b0; rst = 1'b0;
   endtask

   // Reference timeline from the address formulas, one entry per cycle.
   task automatic build_model();
      snap_t e, m;
      int k = 0;
      for (int t = 0; t < TS; t++) begin
         for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < NI; i++) begin
               e = '0; m = strobe_mask();
               e.busy = 1'b1; e.acc_x = 1'b1;
               e.addr_x = AW'(t*NI + i); e.addr_w = AW'(c*NI + i);
               e.addr_b = AW'(c); e.timestep = 3'(t);
               m.addr_x = '1; m.addr_w = '1; m.addr_b = '1; m.timestep = '1;
               exp_a[k] = e; msk_a[k] = m; k++;
            end
            if (!(SKIP && t == 0)) begin
               for (int j = 0; j < NC; j++) begin
                  e = '0; m = strobe_mask();
                  e.busy = 1'b1; e.acc_h = (t != 0);
                  e.addr_x = AW'(t*NI + NI - 1); e.addr_w = AW'(c*NI + NI - 1);
                  e.addr_u = AW'(c*NC + j);
                  e.rd_addr_h = (t == 0) ? '0 : AW'((t-1)*NC + j);
                  e.addr_b = AW'(c); e.timestep = 3'(t);
                  m.addr_x = '1; m.addr_w = '1; m.rd_addr_h = '1; m.addr_b = '1; m.timestep = '1;
                  if (t != 0) m.addr_u = '1;
                  exp_a[k] = e; msk_a[k] = m; k++;
               end
            end
            for (int d = 0; d <= DL; d++) begin
               e = '0; m = strobe_mask();
               e.busy = 1'b1;
               if (d == DL) begin
                  {e.rst_acc, e.wr_act, e.wr_c, e.wr_h} = 4'hF;
                  e.wr_addr_hc = AW'(t*NC + c); m.wr_addr_hc = '1;
               end
               e.addr_x = AW'(t*NI + NI - 1); e.addr_w = AW'(c*NI + NI - 1);
               e.rd_addr_h = (t == 0) ? '0 : AW'((t-1)*NC + NC - 1);
               e.addr_b = AW'(c); e.timestep = 3'(t);
               m.addr_x = '1; m.addr_w = '1; m.rd_addr_h = '1; m.addr_b = '1; m.timestep = '1;
               exp_a[k] = e; msk_a[k] = m; k++;
            end
         end
      end
      e = '0; e.done = 1'b1;
      exp_a[k] = e; msk_a[k] = strobe_mask(); k++;
      exp_a[k] = '0; msk_a[k] = strobe_mask(); k++;
      model_len = k;
   endtask

   task automatic test_reset();
      snap_t s;
      rst = 1'b1; start = 1'b1; stall = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      s = take_snap();
      n_checks++;
      if (s !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", s); end
      @(posedge clk);
      #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_wins_start: busy got %b want 0", busy); end
   endtask

   task automatic test_full_run();
      int nb = 0;
      do_reset();
      pulse_start(1'b0);
      capture(TOTAL + 2, -1, 0, -1, 0, -1, 1'b0);
      for (int k = 0; k < model_len; k++) begin
         n_checks++;
         if (((cap[k] ^ exp_a[k]) & msk_a[k]) !== '0) begin
            n_fail++;
            $display("FAIL full_run cycle %0d: got %h want %h mask %h", k, cap[k], exp_a[k], msk_a[k]);
         end
      end
      for (int k = 0; k < TOTAL + 2; k++) nb += int'(cap[k].busy);
      n_checks++;
      if (nb != TOTAL) begin n_fail++; $display("FAIL full_run_busy: got %0d want %0d", nb, TOTAL); end
   endtask

   task automatic test_cell_pattern();
      int b = SKIP ? 17 : 21;
      int nh = 0;
      do_reset();
      pulse_start(1'b0);
      capture(TOTAL + 2, -1, 0, -1, 0, -1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({cap[b+i].acc_x, cap[b+i].acc_h, cap[b+i].addr_x, cap[b+i].addr_w} !==
             {1'b1, 1'b0, AW'(3 + i), AW'(3 + i)}) begin
            n_fail++;
            $display("FAIL cell1_xph %0d: got x=%0d w=%0d acc_x=%b want x=w=%0d acc_x=1",
                     i, cap[b+i].addr_x, cap[b+i].addr_w, cap[b+i].acc_x, 3 + i);
         end
      end
      for (int j = 0; j < 2; j++) begin
         n_checks++;
         if ({cap[b+3+j].acc_x, cap[b+3+j].acc_h, cap[b+3+j].addr_u, cap[b+3+j].rd_addr_h} !==
             {1'b0, 1'b1, AW'(2 + j), AW'(j)}) begin
            n_fail++;
            $display("FAIL cell1_hph %0d: got u=%0d h=%0d acc_h=%b want u=%0d h=%0d acc_h=1",
                     j, cap[b+3+j].addr_u, cap[b+3+j].rd_addr_h, cap[b+3+j].acc_h, 2 + j, j);
         end
      end
      n_checks++;
      if ({cap[b+5].busy, cap[b+5].acc_x, cap[b+5].acc_h, cap[b+5].rst_acc, cap[b+5].wr_act} !== 5'b10000) begin
         n_fail++; $display("FAIL cell1_drain: got %h want busy only", cap[b+5]);
      end
      n_checks++;
      if ({cap[b+6].wr_act, cap[b+6].wr_c, cap[b+6].wr_h, cap[b+6].rst_acc,
           cap[b+6].wr_addr_hc, cap[b+6].addr_b} !== {4'hF, AW'(3), AW'(1)}) begin
         n_fail++;
         $display("FAIL cell1_write: got wa=%0d b=%0d strobes=%b want wa=3 b=1 strobes=1111",
                  cap[b+6].wr_addr_hc, cap[b+6].addr_b,
                  {cap[b+6].wr_act, cap[b+6].wr_c, cap[b+6].wr_h, cap[b+6].rst_acc});
      end
      for (int k = 0; k < 2*CELL_T0; k++) nh += int'(cap[k].acc_h);
      n_checks++;
      if (nh != 0) begin n_fail++; $display("FAIL t0_acc_h: got %0d cycles want 0", nh); end
   endtask

   task automatic test_stall_xph();
      int nb = 0;
      do_reset();
      pulse_start(1'b0);
      capture(TOTAL + 7, 1, 5, -1, 0, -1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         n_checks++;
         if ({cap[k].busy, cap[k].acc_x, cap[k].addr_x} !== {1'b1, 1'b0, AW'(1)}) begin
            n_fail++;
            $display("FAIL stall_hold %0d: got busy=%b acc_x=%b x=%0d want 1 0 1",
                     k, cap[k].busy, cap[k].acc_x, cap[k].addr_x);
         end
      end
      n_checks++;
      if ({cap[6].acc_x, cap[6].addr_x, cap[7].acc_x, cap[7].addr_x} !== {1'b1, AW'(1), 1'b1, AW'(2)}) begin
         n_fail++;
         $display("FAIL stall_resume: got x=%0d,%0d want 1,2", cap[6].addr_x, cap[7].addr_x);
      end
      for (int k = 0; k < TOTAL + 7; k++) nb += int'(cap[k].busy);
      n_checks++;
      if (nb != TOTAL + 5) begin n_fail++; $display("FAIL stall_busy: got %0d want %0d", nb, TOTAL + 5); end
      n_checks++;
      if ({cap[TOTAL+5].busy, cap[TOTAL+5].done} !== 2'b01) begin
         n_fail++; $display("FAIL stall_done: got busy/done %b%b want 01", cap[TOTAL+5].busy, cap[TOTAL+5].done);
      end
   endtask

   task automatic test_stall_write_done();
      int w  = CELL_T0 - 1;
      int d0 = TOTAL + 2;
      do_reset();
      pulse_start(1'b1);
      capture(d0 + 4, w, 2, d0, 2, -1, 1'b0);
      n_checks++;
      if ({cap[0].busy, cap[0].acc_x} !== 2'b11) begin
         n_fail++; $display("FAIL idle_stall_start: got busy/acc_x %b%b want 11", cap[0].busy, cap[0].acc_x);
      end
      for (int k = w; k < w + 2; k++) begin
         n_checks++;
         if ({cap[k].busy, cap[k].rst_acc, cap[k].wr_act, cap[k].wr_c, cap[k].wr_h} !== 5'b10000) begin
            n_fail++;
            $display("FAIL stall_write %0d: got %b want 10000", k,
                     {cap[k].busy, cap[k].rst_acc, cap[k].wr_act, cap[k].wr_c, cap[k].wr_h});
         end
      end
      n_checks++;
      if ({cap[w+2].wr_act, cap[w+2].wr_addr_hc} !== {1'b1, AW'(0)}) begin
         n_fail++; $display("FAIL stall_write_resume: got wr=%b wa=%0d want 1 0", cap[w+2].wr_act, cap[w+2].wr_addr_hc);
      end
      n_checks++;
      if ({cap[d0].done, cap[d0+1].done, cap[d0+2].done, cap[d0+3].done, cap[d0+2].busy} !== 5'b00100) begin
         n_fail++;
         $display("FAIL done_delay: got %b want 00100",
                  {cap[d0].done, cap[d0+1].done, cap[d0+2].done, cap[d0+3].done, cap[d0+2].busy});
      end
   endtask

   task automatic test_reset_mid();
      int r = SKIP ? 15 : 19;
      int nb = 0;
      do_reset();
      pulse_start(1'b0);
      capture(r + 6, -1, 0, -1, 0, r, 1'b0);
      n_checks++;
      if ({cap[r].busy, cap[r].acc_x, cap[r].acc_h} !== 3'b100) begin
         n_fail++; $display("FAIL mid_rst_drain: got %h want drain cycle", cap[r]);
      end
      for (int k = r + 1; k < r + 6; k++) begin
         n_checks++;
         if (cap[k] !== '0) begin n_fail++; $display("FAIL mid_rst_idle %0d: got %h want 0", k, cap[k]); end
      end
      pulse_start(1'b0);
      capture(TOTAL + 2, -1, 0, -1, 0, -1, 1'b0);
      for (int k = 0; k < model_len; k++) begin
         n_checks++;
         if (((cap[k] ^ exp_a[k]) & msk_a[k]) !== '0) begin
            n_fail++;
            $display("FAIL rerun cycle %0d: got %h want %h mask %h", k, cap[k], exp_a[k], msk_a[k]);
         end
      end
      for (int k = 0; k < TOTAL + 2; k++) nb += int'(cap[k].busy);
      n_checks++;
      if (nb != TOTAL) begin n_fail++; $display("FAIL rerun_busy: got %0d want %0d", nb, TOTAL); end
   endtask

   task automatic test_back_to_back();
      int nb = 0;
      int nd = 0;
      do_reset();
      pulse_start(1'b0);
      capture(2*TOTAL + 4, -1, 0, -1, 0, -1, 1'b1);
      for (int k = 0; k < 2*TOTAL + 4; k++) begin
         nb += int'(cap[k].busy);
         nd += int'(cap[k].done);
      end
      n_checks++;
      if (nb != 2*TOTAL || nd != 2) begin
         n_fail++; $display("FAIL held_start_counts: got busy=%0d done=%0d want %0d 2", nb, nd, 2*TOTAL);
      end
      n_checks++;
      if ({cap[TOTAL].busy, cap[TOTAL].done, cap[TOTAL+1].busy, cap[TOTAL+1].done} !== 4'b0100) begin
         n_fail++;
         $display("FAIL held_start_gap: got %b want 0100",
                  {cap[TOTAL].busy, cap[TOTAL].done, cap[TOTAL+1].busy, cap[TOTAL+1].done});
      end
      n_checks++;
      if ({cap[TOTAL+2].busy, cap[TOTAL+2].acc_x, cap[TOTAL+2].addr_x, cap[TOTAL+2].timestep} !==
          {2'b11, AW'(0), 3'd0}) begin
         n_fail++; $display("FAIL held_start_restart: got %h want busy acc_x x=0 t=0", cap[TOTAL+2]);
      end
      n_checks++;
      if (cap[2*TOTAL+2].done !== 1'b1) begin
         n_fail++; $display("FAIL held_start_done2: got %b want 1", cap[2*TOTAL+2].done);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      build_model();
      test_reset();
      test_full_run();
      test_cell_pattern();
      test_stall_xph();
      test_stall_write_done();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lstm_fwd_sched.md
Name: lstm_fwd_sched

Overview:
Forward-pass sequencer for one LSTM layer of the datapath. For every timestep and cell it streams the x/W products, then the h/U products, into the gate MACs. It then waits for the activation pipeline to drain and issues the activation, state and output write strobes. It replaces the hand-coded forward states of the top-level FSM and the separate W/U/B/x address generators for one layer.

Parameters:
ADDR_WIDTH, 12, width of every address output
TIMESTEP, 7, number of timesteps per sequence
NUM_INPUT, 53, x vector length (W row length)
NUM_CELL, 53, cells in this layer (U row length, h/c vector length)
DELAY, 4, MAC-to-activation pipeline drain cycles before writeback

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a sequence; sampled only in IDLE
stall  in  1  freeze the sequencer; all strobes forced 0 while high
busy  out  1  high from the first XPH cycle through the final WRITE cycle
done  out  1  one-cycle pulse after the final WRITE
acc_x  out  1  accumulate x*W this cycle
acc_h  out  1  accumulate h*U this cycle
rst_acc  out  1  clear the gate accumulators
wr_act  out  1  write gate activations
wr_c  out  1  write cell state
wr_h  out  1  write hidden output
addr_x  out  ADDR_WIDTH  x RAM read address = t*NUM_INPUT+i
addr_w  out  ADDR_WIDTH  W read address = cell*NUM_INPUT+i
addr_u  out  ADDR_WIDTH  U read address = cell*NUM_CELL+j
addr_b  out  ADDR_WIDTH  bias read address = cell
rd_addr_h  out  ADDR_WIDTH  h RAM read address = (t-1)*NUM_CELL+j
wr_addr_hc  out  ADDR_WIDTH  h/c/act write address = t*NUM_CELL+cell
timestep  out  3  current t (0..TIMESTEP-1)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset: state=IDLE; all counters (t, cell, i, j, drain) = 0; every output = 0.
- States and transitions:
  - IDLE: start=1 -> XPH with t=cell=i=0. Otherwise stay.
  - XPH: acc_x=1; i counts 0..NUM_INPUT-1. At i=NUM_INPUT-1 -> HPH with j=0.
  - HPH: acc_h=1; j counts 0..NUM_CELL-1. At the last j -> DRAIN.
  - At t=0 with the macro off, HPH still runs NUM_CELL cycles, but acc_h=0 and rd_addr_h=0 (bubble).
  - DRAIN: DELAY cycles, all strobes 0.
  - WRITE: exactly one cycle; wr_act=wr_c=wr_h=rst_acc=1; wr_addr_hc=t*NUM_CELL+cell. Then:
    - cell<NUM_CELL-1: cell+1 -> XPH.
    - else t<TIMESTEP-1: cell=0, t+1 -> XPH.
    - else -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Per-cell latency: NUM_INPUT+NUM_CELL+DELAY+1 cycles; defaults give 111.
- Total busy cycles: TIMESTEP*NUM_CELL*111 = 41181 at defaults.
- Addresses:
  - Formed with incrementing base registers; no multipliers.
  - addr_x and addr_w are valid in the same cycle acc_x is asserted; addr_u and rd_addr_h likewise with acc_h.
  - addr_b is held for the whole cell.
  - Outside their phases, address outputs hold their last value.
- Stall: all state, counters and addresses hold; acc_x/acc_h/rst_acc/wr_* = 0; busy unchanged; done is delayed (never dropped). Stall in IDLE is ignored; start is still accepted.
- start while busy: ignored. start and rst together: rst wins.
- Reset mid-operation: aborts to IDLE next cycle; no done pulse.
- Width rule: TIMESTEP*NUM_INPUT and NUM_CELL*NUM_CELL must be < 2**ADDR_WIDTH; checked by elaboration-time assertion.

Optional Feature:
LSTM_FWD_SKIP_H0_EN
- Defined: at t=0, WRITE... rather XPH goes directly to DRAIN, skipping HPH (h(-1)=0). t=0 cells take NUM_INPUT+DELAY+1 cycles; default total becomes 38372.
- Undefined: HPH runs as a bubble at t=0, giving uniform per-cell timing.

Decomposition:
- Package lstm_sched_pkg:
  - state enum (IDLE, XPH, HPH, DRAIN, WRITE, DONE)
  - STATE_W constant
  - address-width check function
- One natural sub-module, sched_base_cnt. It is a base+offset address counter with load_base, inc, add_stride and hold inputs. It is instantiated for x/w, u/h and the write address.

Test Plan:
- Small config (NUM_INPUT=3, NUM_CELL=2, TIMESTEP=2, DELAY=1), macro off, start pulse:
  - busy for exactly 28 cycles, then done for 1 cycle.
  - 4 WRITE strobes at wr_addr_hc 0,1,2,3.
- Same config, check per-cell strobe pattern:
  - cell 1 at t=1: acc_x with addr_x=3,4,5 and addr_w=3,4,5.
  - Then acc_h with addr_u=2,3 and rd_addr_h=0,1.
  - Then 1 drain cycle, then WRITE.
- Same config with LSTM_FWD_SKIP_H0_EN: busy 3*... t=0 cells take 5 cycles; total 2*5+2*7=24 cycles; no acc_h at t=0.
- Stall high 5 cycles during XPH at i=1:
  - addr_x frozen at 1 and acc_x=0 during the stall.
  - Resumes at i=1; total busy = 28+5.
- rst asserted during the DRAIN of t=1 cell 0:
  - Next cycle all outputs are 0, state IDLE, no done pulse.
  - A following start produces a clean 28-cycle run.
- start held high continuously:
  - exactly one sequence per IDLE entry.
  - A second run starts the cycle after done; busy low for exactly the DONE and IDLE cycles.
